// File: rtl/data_minus_pkg.sv
// Shared types and defaults for the registered absolute-difference unit.
// The optional a_lt_b sign output is controlled by DATA_MINUS_SIGN_EN.
package data_minus_pkg;

    localparam int DATA_MINUS_WIDTH = 8;

    typedef logic [DATA_MINUS_WIDTH-1:0] operand_t;
    typedef logic [DATA_MINUS_WIDTH:0]   result_t;

endpackage : data_minus_pkg

// File: rtl/abs_diff.sv
// Combinational |a - b| for unsigned operands, plus the a < b compare
// that selects which operand is subtracted from which.
module abs_diff #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             lt
);

    // Subtracting the smaller from the larger keeps the result in WIDTH bits
    // without wrap.
    always_comb begin
        lt   = (a < b);
        diff = lt ? (b - a) : (a - b);
    end

endmodule : abs_diff

// File: rtl/data_abs_minus.sv
// Registered absolute-difference unit: c <= {1'b0, |a - b|} every clock.
// Defining DATA_MINUS_SIGN_EN adds a registered a_lt_b flag with the same latency.
module data_abs_minus
    import data_minus_pkg::*;
#(
    parameter int WIDTH = DATA_MINUS_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DATA_MINUS_SIGN_EN
    output logic [WIDTH:0]   c,
    output logic             a_lt_b
`else
    output logic [WIDTH:0]   c
`endif
);

    logic [WIDTH-1:0] diff_comb;
    logic             lt_comb;

    abs_diff #(
        .WIDTH (WIDTH)
    ) u_abs_diff (
        .a    (a),
        .b    (b),
        .diff (diff_comb),
        .lt   (lt_comb)
    );

    // The top bit is always zero; it exists so signed-difference consumers
    // can take this output without resizing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c <= '0;
        end else begin
            c <= {1'b0, diff_comb};
        end
    end

`ifdef DATA_MINUS_SIGN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_lt_b <= 1'b0;
        end else begin
            a_lt_b <= lt_comb;
        end
    end
`else
    // Without the sign port the compare only steers operand selection.
    logic unused_lt;
    assign unused_lt = lt_comb;
`endif

endmodule : data_abs_minus

// File: tb/tb_data_abs_minus.sv
// Self-checking bench for data_abs_minus: directed reset/boundary cases plus
// random pairs against a plain-arithmetic reference. Handles DATA_MINUS_SIGN_EN.
module tb_data_abs_minus;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   c;
`ifdef DATA_MINUS_SIGN_EN
    logic         a_lt_b;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];
    logic       exp_lt_q[$];

    data_abs_minus #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
`ifdef DATA_MINUS_SIGN_EN
        .c      (c),
        .a_lt_b (a_lt_b)
`else
        .c      (c)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst = 1'b1;
        a   = '0;
        b   = '0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: magnitude of the integer difference, zero-extended.
    function automatic logic [W:0] ref_abs(input logic [W-1:0] x, input logic [W-1:0] y);
        int d;
        d = int'(x) - int'(y);
        if (d < 0) d = -d;
        return d[W:0];
    endfunction

    task automatic check_outputs(input string tag, input logic [W:0] exp_c, input logic exp_lt);
        check_val({tag, "_c"}, 32'(c), 32'(exp_c));
        check_val({tag, "_msb"}, 32'(c[W]), 32'd0);
`ifdef DATA_MINUS_SIGN_EN
        check_val({tag, "_lt"}, 32'(a_lt_b), 32'(exp_lt));
`else
        if (exp_lt === 1'bx) check_val({tag, "_ltx"}, 32'd0, 32'd1);
`endif
    endtask

    // driver: present a pair at the falling edge, check one rising edge later
    task automatic drive_pair(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W:0] exp_c;
        logic       exp_lt;
        @(negedge clk);
        a = av;
        b = bv;
        exp_q.push_back(ref_abs(av, bv));
        exp_lt_q.push_back(av < bv);
        @(posedge clk);
        #1;
        exp_c  = exp_q.pop_front();
        exp_lt = exp_lt_q.pop_front();
        check_outputs(tag, exp_c, exp_lt);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // reset held with clocks running
        a = 8'd100;
        b = 8'd60;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs("reset_hold", '0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset_release", 9'd40, 1'b0);

        drive_pair("a_gt_b", 8'd100, 8'd60);

        // mid-cycle input change must not reach c before the next edge
        @(negedge clk);
        b = 8'd120;
        #2;
        check_outputs("mid_cycle_hold", 9'd40, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("a_lt_b", 9'd20, 1'b1);

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_reset", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("async_release", 9'd20, 1'b1);

        drive_pair("equal", 8'd77, 8'd77);
        drive_pair("max_min", 8'd255, 8'd0);
        drive_pair("min_max", 8'd0, 8'd255);
        drive_pair("zero_zero", 8'd0, 8'd0);
        drive_pair("adj", 8'd128, 8'd129);

        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            drive_pair("random", ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got %0d checks expected completion", checks);
        $fatal(1, "timeout");
    end

endmodule : tb_data_abs_minus

// File: doc/data_abs_minus.md
# data_abs_minus

Registered absolute-difference unit. On every rising clock edge it captures the magnitude of the difference of two unsigned operands, |a − b|, into a registered output one bit wider than the operands. It sits in datapath front-ends wherever a distance or error magnitude is needed, with no handshake: it computes on every cycle.

## Interface
- WIDTH, 8, operand width in bits; output width is WIDTH+1.
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- a  input  WIDTH  unsigned operand.
- b  input  WIDTH  unsigned operand.
- c  output  WIDTH+1  registered |a − b|, zero-extended.
- a_lt_b  output  1  registered flag, 1 when a < b; present only with DATA_MINUS_SIGN_EN.

## Operation
- Combinational compare: a_lt_b_comb = (a < b), unsigned.
- Difference: if a ≥ b then diff = a − b, else diff = b − a; computed at WIDTH bits, no wrap, never negative.
- Register: c <= {1'b0, diff} every clock; no enable, no hold.
- c[WIDTH] is always 0. It is kept for width compatibility with signed-difference consumers.
- a == b gives c = 0, and a_lt_b = 0.
- Extremes: a = 2^WIDTH−1 and b = 0 give c = 2^WIDTH−1; the swapped case gives the same c.
- X on inputs propagates to c; no masking.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on c after edge N.
- Throughput: one result per cycle.
- Reset: while rst=1, c = 0 and a_lt_b = 0, immediately (asynchronous), regardless of clk.
- Reset deassertion: the first edge after rst falls loads a valid result; no extra flush cycle.
- Reset asserted mid-stream clears the output at once; the in-flight result is discarded.
- Input change between edges has no effect on c until the next rising edge.

## Configuration
- DATA_MINUS_SIGN_EN defined: the a_lt_b output port and its register exist. a_lt_b is registered alongside c with identical latency and reset value 0.
- DATA_MINUS_SIGN_EN undefined: no a_lt_b port. Port list is exactly clk, rst, a, b, c, and the compare result is used only internally for operand selection.

## Structure
- Package data_minus_pkg:
  - constant DATA_MINUS_WIDTH = 8, the default for WIDTH;
  - typedef operand_t = logic [DATA_MINUS_WIDTH-1:0];
  - typedef result_t = logic [DATA_MINUS_WIDTH:0].
- Sub-module abs_diff (purely combinational, parameter WIDTH):
  - inputs a and b;
  - outputs diff and lt.
- The top level is the registers, the reset logic and the conditional sign port.

## Test plan
- Reset: rst=1 with a=100, b=60 and clocks running -> c=0 throughout reset; first edge after release -> c=40.
- a > b: a=100, b=60 -> c=40 one edge later; with DATA_MINUS_SIGN_EN, a_lt_b=0.
- a < b: hold a=100, change b to 120 mid-cycle -> c stays 40 until the next edge, then c=20 (and a_lt_b=1 when enabled).
- Boundary values:
  - a=b=77 -> c=0;
  - a=255, b=0 -> c=255;
  - a=0, b=255 -> c=255;
  - c[8]=0 in every case.
- Asynchronous reset mid-operation: assert rst between edges while c=20 -> c=0 immediately, without waiting for an edge; deassert -> next edge reloads the correct value.
- Random: 1000 random a and b pairs, checked each cycle against a one-cycle-delayed reference |a−b|.
